// File: rtl/mem_port_arbiter_if.sv
// Bundle of the two requester ports and the shared memory port.
// slave  : arbiter view (takes requests, drives memory).
// master : environment view (requesters and memory model).
interface mem_port_arbiter_if #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
);
  logic              req0_valid;
  logic              req0_we;
  logic [ADDR_W-1:0] req0_addr;
  logic [DATA_W-1:0] req0_wdata;
  logic              req0_ready;
  logic              rsp0_valid;
  logic [DATA_W-1:0] rsp0_rdata;
  logic              rsp0_err;

  logic              req1_valid;
  logic              req1_we;
  logic [ADDR_W-1:0] req1_addr;
  logic [DATA_W-1:0] req1_wdata;
  logic              req1_ready;
  logic              rsp1_valid;
  logic [DATA_W-1:0] rsp1_rdata;
  logic              rsp1_err;

  logic              mem_valid;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_ready;
  logic [DATA_W-1:0] mem_rdata;

  modport slave (
    input  req0_valid, req0_we, req0_addr, req0_wdata,
    output req0_ready, rsp0_valid, rsp0_rdata, rsp0_err,
    input  req1_valid, req1_we, req1_addr, req1_wdata,
    output req1_ready, rsp1_valid, rsp1_rdata, rsp1_err,
    output mem_valid, mem_we, mem_addr, mem_wdata,
    input  mem_ready, mem_rdata
  );

  modport master (
    output req0_valid, req0_we, req0_addr, req0_wdata,
    input  req0_ready, rsp0_valid, rsp0_rdata, rsp0_err,
    output req1_valid, req1_we, req1_addr, req1_wdata,
    input  req1_ready, rsp1_valid, rsp1_rdata, rsp1_err,
    input  mem_valid, mem_we, mem_addr, mem_wdata,
    output mem_ready, mem_rdata
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Two-port round-robin arbiter in front of a single-port memory.
// Port 0 = instruction fetch, port 1 = load/store. One transaction in flight.
// Optional: define ARB_TIMEOUT_EN to abort BUSY after TIMEOUT cycles without mem_ready.
module mem_port_arbiter #(
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned TIMEOUT = 255
) (
  input logic               clk,
  input logic               reset,
  mem_port_arbiter_if.slave bus
);

  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

  state_t            state, state_next;
  logic              last_grant;
  logic              grant_id;
  logic              lat_we;
  logic [ADDR_W-1:0] lat_addr;
  logic [DATA_W-1:0] lat_wdata;

  logic              any_req;
  logic              win_id;
  logic              accept;
  logic              finish;
  logic              tmo_abort;

  logic              rsp0_valid_q, rsp1_valid_q;
  logic [DATA_W-1:0] rsp0_rdata_q, rsp1_rdata_q;

  // Winner selection: single requester wins; on a tie the port that did not win last.
  always_comb begin
    any_req = bus.req0_valid | bus.req1_valid;
    win_id  = (bus.req0_valid & bus.req1_valid) ? ~last_grant : bus.req1_valid;
    accept  = (state == IDLE) & any_req;
    finish  = (state == BUSY) & (bus.mem_ready | tmo_abort);
  end

`ifdef ARB_TIMEOUT_EN
  localparam int unsigned TMO_W = $clog2(TIMEOUT + 1);
  logic [TMO_W-1:0] tmo_cnt;

  // BUSY cycle counter, restarted on every accepted request.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)            tmo_cnt <= '0;
    else if (accept)       tmo_cnt <= '0;
    else if (state == BUSY) tmo_cnt <= tmo_cnt + TMO_W'(1);
  end

  assign tmo_abort = (state == BUSY) && (tmo_cnt == TMO_W'(TIMEOUT)) && !bus.mem_ready;

  logic rsp0_err_q, rsp1_err_q;

  // Error flag pulses alongside the response of an aborted transaction.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rsp0_err_q <= 1'b0;
      rsp1_err_q <= 1'b0;
    end else begin
      rsp0_err_q <= tmo_abort & ~grant_id;
      rsp1_err_q <= tmo_abort &  grant_id;
    end
  end

  assign bus.rsp0_err = rsp0_err_q;
  assign bus.rsp1_err = rsp1_err_q;
`else
  assign tmo_abort    = 1'b0;
  assign bus.rsp0_err = 1'b0;
  assign bus.rsp1_err = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_next;
  end

  // Next-state logic: IDLE -> BUSY on accept, BUSY -> IDLE on completion or abort.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (accept) state_next = BUSY;
      BUSY:    if (finish) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Latch the winning request and track grant history.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      last_grant <= 1'b1;
      grant_id   <= 1'b0;
      lat_we     <= 1'b0;
      lat_addr   <= '0;
      lat_wdata  <= '0;
    end else begin
      if (accept) begin
        grant_id  <= win_id;
        lat_we    <= win_id ? bus.req1_we    : bus.req0_we;
        lat_addr  <= win_id ? bus.req1_addr  : bus.req0_addr;
        lat_wdata <= win_id ? bus.req1_wdata : bus.req0_wdata;
      end
      if (finish) last_grant <= grant_id;
    end
  end

  // Response pulses and per-port read data holding registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rsp0_valid_q <= 1'b0;
      rsp1_valid_q <= 1'b0;
      rsp0_rdata_q <= '0;
      rsp1_rdata_q <= '0;
    end else begin
      rsp0_valid_q <= finish & ~grant_id;
      rsp1_valid_q <= finish &  grant_id;
      if (finish && !grant_id) begin
        if (tmo_abort)   rsp0_rdata_q <= '0;
        else if (!lat_we) rsp0_rdata_q <= bus.mem_rdata;
      end
      if (finish && grant_id) begin
        if (tmo_abort)   rsp1_rdata_q <= '0;
        else if (!lat_we) rsp1_rdata_q <= bus.mem_rdata;
      end
    end
  end

  assign bus.req0_ready = accept & ~win_id;
  assign bus.req1_ready = accept &  win_id;
  assign bus.rsp0_valid = rsp0_valid_q;
  assign bus.rsp1_valid = rsp1_valid_q;
  assign bus.rsp0_rdata = rsp0_rdata_q;
  assign bus.rsp1_rdata = rsp1_rdata_q;
  assign bus.mem_valid  = (state == BUSY);
  assign bus.mem_we     = lat_we;
  assign bus.mem_addr   = lat_addr;
  assign bus.mem_wdata  = lat_wdata;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter. Define ARB_TIMEOUT_EN to exercise the abort path.
module tb_mem_port_arbiter;

`ifdef ARB_TIMEOUT_EN
  localparam int unsigned TMO = 4;
`else
  localparam int unsigned TMO = 255;
`endif

  logic clk;
  logic reset;
  int   total;
  int   bad;
  int   n0;
  int   n1;

  mem_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus_if ();

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(TMO)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_if.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    total = 0; bad = 0; n0 = 0; n1 = 0;
    reset = 1'b0;
    bus_if.req0_valid = 0; bus_if.req0_we = 0; bus_if.req0_addr = '0; bus_if.req0_wdata = '0;
    bus_if.req1_valid = 0; bus_if.req1_we = 0; bus_if.req1_addr = '0; bus_if.req1_wdata = '0;
    bus_if.mem_ready = 0;  bus_if.mem_rdata = '0;
    cyc(); cyc();

    // Reset state
    chk("rst_mem_valid", 32'(bus_if.mem_valid), 32'd0);
    chk("rst_rsp0_valid", 32'(bus_if.rsp0_valid), 32'd0);
    chk("rst_rsp1_valid", 32'(bus_if.rsp1_valid), 32'd0);
    chk("rst_rsp0_rdata", bus_if.rsp0_rdata, 32'd0);
    chk("rst_rsp1_rdata", bus_if.rsp1_rdata, 32'd0);
    chk("rst_mem_addr", bus_if.mem_addr, 32'd0);
    chk("rst_err", 32'({bus_if.rsp0_err, bus_if.rsp1_err}), 32'd0);
    reset = 1'b1;
    cyc();

    // Single read on port 0, one wait cycle
    bus_if.req0_valid = 1; bus_if.req0_addr = 32'h10;
    #1;
    chk("rd_req0_ready", 32'(bus_if.req0_ready), 32'd1);
    chk("rd_req1_ready", 32'(bus_if.req1_ready), 32'd0);
    cyc();
    bus_if.req0_valid = 0;
    #1;
    chk("rd_mem_valid", 32'(bus_if.mem_valid), 32'd1);
    chk("rd_mem_addr", bus_if.mem_addr, 32'h10);
    chk("rd_mem_we", 32'(bus_if.mem_we), 32'd0);
    chk("rd_busy_ready", 32'(bus_if.req0_ready), 32'd0);
    cyc();
    bus_if.mem_ready = 1; bus_if.mem_rdata = 32'hDEADBEEF;
    chk("rd_no_early_rsp", 32'(bus_if.rsp0_valid), 32'd0);
    cyc();
    bus_if.mem_ready = 0;
    chk("rd_rsp0_valid", 32'(bus_if.rsp0_valid), 32'd1);
    chk("rd_rsp0_rdata", bus_if.rsp0_rdata, 32'hDEADBEEF);
    chk("rd_rsp0_err", 32'(bus_if.rsp0_err), 32'd0);
    chk("rd_rsp1_valid", 32'(bus_if.rsp1_valid), 32'd0);
    chk("rd_mem_idle", 32'(bus_if.mem_valid), 32'd0);
    cyc();
    chk("rd_pulse_end", 32'(bus_if.rsp0_valid), 32'd0);
    chk("rd_rdata_hold", bus_if.rsp0_rdata, 32'hDEADBEEF);

    // Tie right after reset: port 0 first, then port 1
    reset = 1'b0; cyc(); reset = 1'b1; cyc();
    bus_if.req0_valid = 1; bus_if.req0_addr = 32'h100;
    bus_if.req1_valid = 1; bus_if.req1_addr = 32'h200;
    bus_if.mem_ready = 1; bus_if.mem_rdata = 32'hA0;
    #1;
    chk("tie_req0_ready", 32'(bus_if.req0_ready), 32'd1);
    chk("tie_req1_ready", 32'(bus_if.req1_ready), 32'd0);
    cyc();
    bus_if.req0_valid = 0;
    #1;
    chk("tie_mem_addr0", bus_if.mem_addr, 32'h100);
    chk("tie_busy_req1", 32'(bus_if.req1_ready), 32'd0);
    cyc();
    bus_if.mem_rdata = 32'hB1;
    #1;
    chk("tie_rsp0_valid", 32'(bus_if.rsp0_valid), 32'd1);
    chk("tie_rsp0_rdata", bus_if.rsp0_rdata, 32'hA0);
    chk("tie_req1_ready_now", 32'(bus_if.req1_ready), 32'd1);
    cyc();
    bus_if.req1_valid = 0;
    #1;
    chk("tie_mem_addr1", bus_if.mem_addr, 32'h200);
    cyc();
    chk("tie_rsp1_valid", 32'(bus_if.rsp1_valid), 32'd1);
    chk("tie_rsp1_rdata", bus_if.rsp1_rdata, 32'hB1);
    chk("tie_rsp0_hold", bus_if.rsp0_rdata, 32'hA0);

    // Fairness: both held valid for 8 transactions, last grant was port 1
    bus_if.req0_valid = 1; bus_if.req0_addr = 32'h300;
    bus_if.req1_valid = 1; bus_if.req1_addr = 32'h400;
    for (int i = 0; i < 8; i++) begin
      bus_if.mem_rdata = 32'h100 + 32'(i);
      #1;
      chk("fair_req0_ready", 32'(bus_if.req0_ready), 32'((i % 2) == 0));
      chk("fair_req1_ready", 32'(bus_if.req1_ready), 32'((i % 2) == 1));
      cyc();
      chk("fair_mem_addr", bus_if.mem_addr, ((i % 2) == 0) ? 32'h300 : 32'h400);
      cyc();
      if (bus_if.rsp0_valid) n0++;
      if (bus_if.rsp1_valid) n1++;
      chk("fair_rsp_port", 32'({bus_if.rsp1_valid, bus_if.rsp0_valid}),
          ((i % 2) == 0) ? 32'd1 : 32'd2);
    end
    bus_if.req0_valid = 0; bus_if.req1_valid = 0;
    chk("fair_n0", 32'(n0), 32'd4);
    chk("fair_n1", 32'(n1), 32'd4);
    chk("fair_rdata1", bus_if.rsp1_rdata, 32'h107);

    // Write on port 1 with 5 wait states
    bus_if.mem_ready = 0; bus_if.mem_rdata = 32'hFFFFFFFF;
    bus_if.req1_valid = 1; bus_if.req1_we = 1; bus_if.req1_addr = 32'h20; bus_if.req1_wdata = 32'h1234;
    #1;
    chk("wr_req1_ready", 32'(bus_if.req1_ready), 32'd1);
    cyc();
    bus_if.req1_valid = 0; bus_if.req1_we = 0; bus_if.req1_addr = '0; bus_if.req1_wdata = '0;
    for (int k = 0; k < 6; k++) begin
      #1;
      chk("wr_mem_valid", 32'(bus_if.mem_valid), 32'd1);
      chk("wr_mem_fields", {bus_if.mem_addr[15:0], bus_if.mem_wdata[14:0], bus_if.mem_we},
          {16'h20, 15'h1234, 1'b1});
      chk("wr_no_rsp", 32'(bus_if.rsp1_valid), 32'd0);
      if (k == 5) bus_if.mem_ready = 1;
      cyc();
    end
    bus_if.mem_ready = 0;
    chk("wr_rsp1_valid", 32'(bus_if.rsp1_valid), 32'd1);
    chk("wr_rsp1_rdata_kept", bus_if.rsp1_rdata, 32'h107);
    chk("wr_mem_idle", 32'(bus_if.mem_valid), 32'd0);

    // mem_ready while IDLE is ignored
    bus_if.mem_ready = 1;
    cyc();
    bus_if.mem_ready = 0;
    chk("idle_ready_ignored", 32'({bus_if.rsp1_valid, bus_if.rsp0_valid, bus_if.mem_valid}), 32'd0);

    // Port 0 read so last_grant becomes 0, then reset during a port 1 BUSY
    bus_if.req0_valid = 1; bus_if.req0_addr = 32'h50; bus_if.mem_ready = 1; bus_if.mem_rdata = 32'h55;
    cyc();
    bus_if.req0_valid = 0;
    cyc();
    chk("pre_rsp0_rdata", bus_if.rsp0_rdata, 32'h55);
    bus_if.mem_ready = 0;
    bus_if.req1_valid = 1; bus_if.req1_addr = 32'h60;
    cyc();
    bus_if.req1_valid = 0;
    #1;
    chk("mid_busy", 32'(bus_if.mem_valid), 32'd1);
    reset = 1'b0;
    #1;
    chk("mid_rst_mem_valid", 32'(bus_if.mem_valid), 32'd0);
    chk("mid_rst_rsp1", 32'(bus_if.rsp1_valid), 32'd0);
    chk("mid_rst_rdata0", bus_if.rsp0_rdata, 32'd0);
    bus_if.mem_ready = 1;
    cyc(); cyc();
    reset = 1'b1; bus_if.mem_ready = 0;
    cyc();
    chk("post_rst_no_rsp", 32'({bus_if.rsp1_valid, bus_if.rsp0_valid, bus_if.mem_valid}), 32'd0);
    bus_if.req0_valid = 1; bus_if.req1_valid = 1;
    #1;
    chk("post_rst_tie0", 32'(bus_if.req0_ready), 32'd1);
    chk("post_rst_tie1", 32'(bus_if.req1_ready), 32'd0);
    cyc();
    bus_if.req0_valid = 0; bus_if.req1_valid = 0;
    bus_if.mem_ready = 1; bus_if.mem_rdata = 32'h77;
    cyc();
    bus_if.mem_ready = 0;
    chk("post_rst_rsp0", 32'({bus_if.rsp1_valid, bus_if.rsp0_valid}), 32'd1);
    chk("post_rst_rdata0", bus_if.rsp0_rdata, 32'h77);
    cyc();

    // Stuck memory on port 0
    bus_if.req0_valid = 1; bus_if.req0_addr = 32'h70;
    cyc();
    bus_if.req0_valid = 0;
`ifdef ARB_TIMEOUT_EN
    for (int k = 0; k < 5; k++) begin
      #1;
      chk("tmo_mem_valid", 32'(bus_if.mem_valid), 32'd1);
      chk("tmo_no_rsp", 32'(bus_if.rsp0_valid), 32'd0);
      cyc();
    end
    chk("tmo_mem_drop", 32'(bus_if.mem_valid), 32'd0);
    chk("tmo_rsp0_valid", 32'(bus_if.rsp0_valid), 32'd1);
    chk("tmo_rsp0_err", 32'(bus_if.rsp0_err), 32'd1);
    chk("tmo_rsp0_rdata", bus_if.rsp0_rdata, 32'd0);
    cyc();
    chk("tmo_err_pulse", 32'({bus_if.rsp0_err, bus_if.rsp0_valid}), 32'd0);
`else
    for (int k = 0; k < 8; k++) begin
      #1;
      chk("wait_mem_valid", 32'(bus_if.mem_valid), 32'd1);
      chk("wait_no_rsp", 32'(bus_if.rsp0_valid), 32'd0);
      cyc();
    end
    bus_if.mem_ready = 1; bus_if.mem_rdata = 32'h99;
    cyc();
    bus_if.mem_ready = 0;
    chk("wait_rsp0_valid", 32'(bus_if.rsp0_valid), 32'd1);
    chk("wait_rsp0_err", 32'(bus_if.rsp0_err), 32'd0);
    chk("wait_rsp0_rdata", bus_if.rsp0_rdata, 32'h99);
`endif

    // Next request completes normally
    bus_if.req1_valid = 1; bus_if.req1_addr = 32'h80; bus_if.mem_ready = 1; bus_if.mem_rdata = 32'hAB;
    #1;
    chk("next_req1_ready", 32'(bus_if.req1_ready), 32'd1);
    cyc();
    bus_if.req1_valid = 0;
    cyc();
    bus_if.mem_ready = 0;
    chk("next_rsp1_valid", 32'(bus_if.rsp1_valid), 32'd1);
    chk("next_rsp1_err", 32'(bus_if.rsp1_err), 32'd0);
    chk("next_rsp1_rdata", bus_if.rsp1_rdata, 32'hAB);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
